hazard_sequencer: RTL



---
 rtl/hazard_sequencer_if.sv | 26 ++
 rtl/hazard_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer_if.sv
// Front-end hazard control bundle: ID/EX status inputs and the pipeline enables plus perf counters.
interface hazard_sequencer_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_redirect;
  logic        mem_busy;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;

  modport master (
    output id_valid, id_instr, ex_redirect, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
    input  stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  id_valid, id_instr, ex_redirect, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
    output stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use / redirect / memory-wait hazard sequencing for the 5-stage core front end,
// with saturating per-hazard performance counters.
module hazard_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  hazard_sequencer_if.slave  bus
);
  localparam logic [6:0] LOAD_OPERATION    = 7'b0000011;
  localparam logic [6:0] STORE_OPERATION   = 7'b0100011;
  localparam logic [6:0] BRANCH_OPERATION  = 7'b1100011;
  localparam logic [6:0] JALR_OPERATION    = 7'b1100111;
  localparam logic [6:0] JAL_OPERATION     = 7'b1101111;
  localparam logic [6:0] LUI_OPERATION     = 7'b0110111;
  localparam logic [6:0] AUIPC_OPERATION   = 7'b0010111;
  localparam logic [6:0] ART_IMM_OPERATION = 7'b0010011;
  localparam logic [6:0] R_TYPE_OPERATION  = 7'b0110011;

  typedef enum logic [1:0] {RUN, FROZEN, FROZEN_REDIR} state_e;

  state_e      state_q, state_d;
  logic        ex_valid_q, ex_valid_d;
  logic        ex_load_q, ex_load_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] freeze_cnt_q, freeze_cnt_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2;
  logic        use_rs1, use_rs2, lu;
  logic        frozen, flush, stall;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        unused_instr_bits;

  assign opcode            = bus.id_instr[6:0];
  assign rs1               = bus.id_instr[19:15];
  assign rs2               = bus.id_instr[24:20];
  assign unused_instr_bits = ^{bus.id_instr[31:25], bus.id_instr[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      R_TYPE_OPERATION, STORE_OPERATION, BRANCH_OPERATION: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      ART_IMM_OPERATION, LOAD_OPERATION, JALR_OPERATION: use_rs1 = 1'b1;
      LUI_OPERATION, AUIPC_OPERATION, JAL_OPERATION:     use_rs1 = 1'b0;
      default:                                           use_rs1 = 1'b0;
    endcase
  end

  // x0 is never a real producer, so a load to x0 must not stall.
  assign lu = bus.id_valid && ex_valid_q && ex_load_q && (ex_rd_q != '0) &&
              ((use_rs1 && (rs1 == ex_rd_q)) || (use_rs2 && (rs2 == ex_rd_q)));

  always_comb begin
    state_d     = state_q;
    frozen      = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.mem_busy) state_d = bus.ex_redirect ? FROZEN_REDIR : FROZEN;
      end
      FROZEN: begin
        if (!bus.mem_busy)        state_d = RUN;
        else if (bus.ex_redirect) state_d = FROZEN_REDIR;
      end
      FROZEN_REDIR: begin
        if (!bus.mem_busy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (bus.mem_busy) begin
      frozen     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (bus.ex_redirect || (state_q == FROZEN_REDIR)) begin
      flush       = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      stall       = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_load_d  = ex_load_q;
    ex_rd_d    = ex_rd_q;
    if (!frozen) begin
      if (idex_bubble) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = bus.id_valid;
        ex_load_d  = (opcode == LOAD_OPERATION);
        ex_rd_d    = bus.id_instr[11:7];
      end
    end

    stall_cnt_d  = (stall  && (stall_cnt_q  != '1)) ? stall_cnt_q  + 32'd1 : stall_cnt_q;
    flush_cnt_d  = (flush  && (flush_cnt_q  != '1)) ? flush_cnt_q  + 32'd1 : flush_cnt_q;
    freeze_cnt_d = (frozen && (freeze_cnt_q != '1)) ? freeze_cnt_q + 32'd1 : freeze_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_load_q    <= 1'b0;
      ex_rd_q      <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_load_q    <= ex_load_d;
      ex_rd_q      <= ex_rd_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.freeze_cnt  = freeze_cnt_q;
endmodule
